// File: rtl/sram_mem_ctrl_if.sv
// Bus bundle between the MEM-stage pipeline and the data-memory controller,
// including the pin-level signals toward the external asynchronous SRAM.
interface sram_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              Mem_R_En;
  logic              Mem_W_En;
  logic [31:0]       Addr;
  logic [31:0]       Wr_Data;
  logic [31:0]       Rd_Data;
  logic              Ready;
  logic [ADDR_W-1:0] SRAM_Addr;
  logic [15:0]       SRAM_Dout;
  logic [15:0]       SRAM_Din;
  logic              SRAM_DQ_Oe;
  logic              SRAM_WE_N;

  modport slave (
    input  Mem_R_En, Mem_W_En, Addr, Wr_Data, SRAM_Din,
    output Rd_Data, Ready, SRAM_Addr, SRAM_Dout, SRAM_DQ_Oe, SRAM_WE_N
  );

  modport master (
    output Mem_R_En, Mem_W_En, Addr, Wr_Data, SRAM_Din,
    input  Rd_Data, Ready, SRAM_Addr, SRAM_Dout, SRAM_DQ_Oe, SRAM_WE_N
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// 16-bit asynchronous SRAM accesses and holds Ready low until it completes.
module sram_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned WAIT      = 2
) (
  input  logic           clk,
  input  logic           rst,
  sram_mem_ctrl_if.slave bus
);
  localparam int unsigned      IDX_W    = ADDR_W - 1;
  localparam int unsigned      CNT_W    = (WAIT > 2) ? $clog2(WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       data;
  logic              wr;
  logic [31:0]       rd_data;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dout;
  logic              sram_oe;
  logic              sram_we_n;

  logic              req;
  logic [IDX_W-1:0]  req_idx;
  logic [CNT_W-1:0]  cnt_inc;
  logic              half_last;

  assign req       = bus.Mem_R_En | bus.Mem_W_En;
  assign req_idx   = IDX_W'((bus.Addr - BASE_ADDR) >> 2);
  assign cnt_inc   = cnt + CNT_W'(1);
  assign half_last = (cnt == CNT_LAST);

  // Freeze begins in the same cycle a request appears; release in DONE.
  assign bus.Ready      = ((state == IDLE) && !req) || (state == DONE);
  assign bus.Rd_Data    = rd_data;
  assign bus.SRAM_Addr  = sram_addr;
  assign bus.SRAM_Dout  = sram_dout;
  assign bus.SRAM_DQ_Oe = sram_oe;
  assign bus.SRAM_WE_N  = sram_we_n;

  // SRAM pin values are loaded one edge ahead so they are registered yet
  // valid for the whole cycle they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      data      <= '0;
      wr        <= 1'b0;
      rd_data   <= '0;
      sram_addr <= '0;
      sram_dout <= '0;
      sram_oe   <= 1'b0;
      sram_we_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx       <= req_idx;
            data      <= bus.Wr_Data;
            wr        <= bus.Mem_W_En;
            cnt       <= '0;
            sram_addr <= {req_idx, 1'b0};
            sram_dout <= bus.Wr_Data[15:0];
            sram_oe   <= bus.Mem_W_En;
            sram_we_n <= !bus.Mem_W_En;
            state     <= LO;
          end
        end
        LO: begin
          if (half_last) begin
            if (!wr) rd_data[15:0] <= bus.SRAM_Din;
            cnt       <= '0;
            sram_addr <= {idx, 1'b1};
            sram_dout <= data[31:16];
            sram_we_n <= !wr;
            state     <= HI;
          end else begin
            cnt       <= cnt_inc;
            sram_we_n <= !(wr && (cnt_inc != CNT_LAST));
          end
        end
        HI: begin
          if (half_last) begin
            if (!wr) rd_data[31:16] <= bus.SRAM_Din;
            cnt       <= '0;
            sram_oe   <= 1'b0;
            sram_we_n <= 1'b1;
            state     <= DONE;
          end else begin
            cnt       <= cnt_inc;
            sram_we_n <= !(wr && (cnt_inc != CNT_LAST));
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Multi-cycle data-memory controller for the MEM stage of the ARM pipeline. It takes the memory-read/write request carried out of the EXE/MEM pipeline register, sequences a 32-bit access as two 16-bit accesses on an external asynchronous SRAM, and drives `Ready` low so the hazard/freeze logic stalls every pipeline register until the access completes.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `ADDR_W`, 18: SRAM address width in 16-bit halfwords.
- `WAIT`, 2: clock cycles per halfword access. Legal range is ≥2; values below 2 are illegal.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: **asynchronous, active-low** reset.
- `Mem_R_En` in 1: load request from EXE/MEM register.
- `Mem_W_En` in 1: store request from EXE/MEM register.
- `Addr` in 32: byte address (ALU result).
- `Wr_Data` in 32: store data (Val_Rm).
- `Rd_Data` out 32: load result; registered.
- `Ready` out 1: 0 means freeze the pipeline; combinational.
- `SRAM_Addr` out ADDR_W: halfword address; registered.
- `SRAM_Dout` out 16: write data to the SRAM DQ driver; registered.
- `SRAM_Din` in 16: read data from the SRAM DQ pins.
- `SRAM_DQ_Oe` out 1: 1 means the top level drives DQ with `SRAM_Dout`.
- `SRAM_WE_N` out 1: SRAM write enable, active-low.

## Operation
- **Request:** `req = Mem_R_En | Mem_W_En`. If both are high, the request is a write.
- **Address:** `idx = ((Addr - BASE_ADDR) >> 2)`, 32-bit subtract, truncated to ADDR_W-1 bits.
  - `Addr[1:0]` is ignored.
  - Addresses below `BASE_ADDR` wrap modulo 2^(ADDR_W-1) with no error.
- **Latch:** on accepting a request, latch `idx`, `Wr_Data` and the op. The rest of the access uses only these latched values, so input changes mid-access are ignored.
- **FSM states:** IDLE, LO, HI, DONE. A counter `cnt` runs 0..WAIT-1 inside LO and HI.
  - **IDLE:** if `req`, latch the request, set `cnt=0`, go to LO. Otherwise stay.
  - **LO:** `SRAM_Addr={idx,1'b0}`.
    - Write: `SRAM_Dout=data[15:0]`, `SRAM_DQ_Oe=1`, `SRAM_WE_N=0` for `cnt`<WAIT-1, then 1 when `cnt`=WAIT-1.
    - Read: `SRAM_DQ_Oe=0`, `SRAM_WE_N=1`; sample `SRAM_Din` into the low half of `Rd_Data` at the edge ending `cnt`=WAIT-1.
    - At that edge, go to HI with `cnt=0`.
  - **HI:** same as LO with `SRAM_Addr={idx,1'b1}` and `data[31:16]` (write) or the high half of `Rd_Data` (read). At the edge ending `cnt`=WAIT-1, go to DONE.
  - **DONE:** one cycle. `SRAM_WE_N=1`, `SRAM_DQ_Oe=0`. Next state is IDLE.
- **Ready:** `Ready = (state==IDLE & ~req) | (state==DONE)`.
  - A new request therefore freezes the pipeline in the same cycle it appears.
  - The pipeline advances on the edge that ends DONE.
- **Rd_Data:** holds the last completed load value. Writes never modify it. Both halves are updated only by a read.
- **SRAM outputs outside LO/HI:** `SRAM_WE_N=1`, `SRAM_DQ_Oe=0`. `SRAM_Addr` and `SRAM_Dout` hold their last values.

## Timing
- **Reset (rst=0), immediate and asynchronous:**
  - state=IDLE, `cnt=0`
  - `Rd_Data=0`, `SRAM_Addr=0`, `SRAM_Dout=0`
  - `SRAM_WE_N=1`, `SRAM_DQ_Oe=0`
  - `Ready` follows its equation; with `req=0` it is 1.
- **Reset mid-access:** the access aborts and the write strobe deasserts at once. No retry after reset.
- **Latency:** request seen in IDLE in cycle 0.
  - LO occupies cycles 1..WAIT; HI occupies WAIT+1..2·WAIT; DONE is cycle 2·WAIT+1.
  - `Ready` is 0 for 2·WAIT+1 cycles. With WAIT=2: `Ready` is low in cycles 0–4 and high in cycle 5.
- **Load data:** `Rd_Data` is valid from the start of DONE, i.e. in the cycle where `Ready`=1, so the MEM/WB register captures it on that edge.
- **Write strobe per half:** `SRAM_WE_N` is low for WAIT-1 cycles and high in the last cycle. The address and data are stable for the whole half, so the address never changes while WE_N is low.
- **Back-to-back memory ops:** the new request is seen in the IDLE cycle after DONE. There is no dead cycle beyond DONE.
- **Request dropped mid-access:** this cannot happen while frozen. If it does, the latched access still completes.

## Test plan
- **Reset:** hold rst=0 with `Mem_R_En=1` → `SRAM_WE_N=1`, `SRAM_DQ_Oe=0`, `Rd_Data=0`. Release → `Ready`=0 in the same cycle and the FSM enters LO.
- **Store:** WAIT=2, store `Addr=1028`, `Wr_Data=0xDEADBEEF`.
  - Required: `SRAM_Addr=2` with `SRAM_Dout=0xBEEF`, then `SRAM_Addr=3` with `SRAM_Dout=0xDEAD`.
  - Required: `SRAM_WE_N` low exactly 1 cycle per half.
  - Required: `Ready` low cycles 0–4, high cycle 5; `Rd_Data` unchanged.
- **Load:** SRAM model holds halfword 2 = 0xBEEF and halfword 3 = 0xDEAD; load `Addr=1029` → `Rd_Data=0xDEADBEEF` in the DONE cycle, `SRAM_DQ_Oe` stays 0.
- **Back-to-back:** store then load to `Addr=1024` on consecutive instructions → second access begins in the cycle after DONE, 5+5 freeze cycles, load returns the stored word.
- **Corner cases:** `Mem_R_En=Mem_W_En=1` → treated as a write. `Addr=1020` → `idx` wraps to 2^(ADDR_W-1)-1, `SRAM_Addr` = 0x3FFFE then 0x3FFFF.
- **Abort:** rst asserted in HI during a write → `SRAM_WE_N=1` immediately. After release, `Ready`=1 in IDLE with `req=0`.
